// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit for the MEM stage.
// Puts a req/resp handshake in front of an internal byte-enabled,
// synchronous-read RAM. Decodes RISC-V funct3 width/sign, sign/zero extends
// loads, provides a ROM read path, and splits misaligned accesses that cross
// a word boundary into two beats.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-low reset
//   i_req_valid/o_req_ready  request handshake (ready only in IDLE)
//   i_req_write           1 = store, 0 = load
//   i_addr                byte address (AW word bits + BW offset bits)
//   i_memWidth            funct3 width/sign code
//   i_writeData           right-justified store data
//   i_dataSelect          load from the ROM path instead of RAM
//   i_IM_readData         ROM read data
//   o_resp_valid          one-cycle completion pulse
//   o_readData            formatted load result, held between loads
//   o_err                 illegal request flag, valid with o_resp_valid
module dmem_lsu #(
  parameter int N  = 64,
  parameter int M  = 32,
  parameter int AW = 12,
  localparam int BW = $clog2(N/8)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [AW+BW-1:0]  i_addr,
  input  logic [2:0]        i_memWidth,
  input  logic [N-1:0]      i_writeData,
  input  logic              i_dataSelect,
  input  logic [M-1:0]      i_IM_readData,
  output logic              o_resp_valid,
  output logic [N-1:0]      o_readData,
  output logic              o_err
);

  localparam int NB = N/8;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

  state_t r_state, w_nextState;

  logic              r_err, r_write, r_rom, r_split, r_uns;
  logic [BW-1:0]     r_offset;
  logic [1:0]        r_sz;
  logic [AW-1:0]     r_wordNext;
  logic [NB-1:0]     r_hiMask;
  logic [N-1:0]      r_hiData, r_beat, r_ramQ, r_readData;
  logic [N-1:0]      r_mem [0:(1<<AW)-1];

  logic              w_accept, w_illegal, w_split, w_we, w_signBit;
  logic [BW-1:0]     w_offset;
  logic [AW-1:0]     w_word, w_waddr, w_raddr;
  logic [1:0]        w_sz;
  logic [4:0]        w_sizeBytes;
  logic [2*NB-1:0]   w_baseMask, w_maskWide;
  logic [2*N-1:0]    w_dataWide, w_loadWide;
  logic [NB-1:0]     w_wmask;
  logic [N-1:0]      w_wdata, w_raw, w_loadResult, w_romExt;
  int                w_nbits;

  assign w_accept    = i_req_valid && o_req_ready;
  assign w_offset    = i_addr[BW-1:0];
  assign w_word      = i_addr[AW+BW-1:BW];
  assign w_sz        = i_memWidth[1:0];
  assign w_sizeBytes = 5'd1 << w_sz;

  // The ROM path ignores addr/width, so only a store makes it illegal.
  always_comb begin
    w_illegal = 1'b0;
    w_split   = 1'b0;
    if (i_dataSelect) begin
      w_illegal = i_req_write;
    end else begin
      w_illegal = (i_memWidth == 3'b111) || (i_req_write && i_memWidth[2]) ||
                  (int'(w_sizeBytes) > NB);
      w_split   = (int'(w_offset) + int'(w_sizeBytes)) > NB;
    end
  end

  // Store mask and data are shifted into a double-word window; the upper
  // half is what spills into the following word on a split store.
  assign w_baseMask = ({{(2*NB-1){1'b0}}, 1'b1} << w_sizeBytes) - 1'b1;
  assign w_maskWide = w_baseMask << w_offset;
  assign w_dataWide = {{N{1'b0}}, i_writeData} << {w_offset, 3'b000};

  // Only one RAM write per cycle: beat 1 from live inputs in IDLE, beat 2
  // from the registered high half in BEAT2.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_word;
    w_wmask = w_maskWide[NB-1:0];
    w_wdata = w_dataWide[N-1:0];
    if (r_state == IDLE && w_accept && i_req_write && !w_illegal) begin
      w_we = 1'b1;
    end else if (r_state == BEAT2 && r_write) begin
      w_we    = 1'b1;
      w_waddr = r_wordNext;
      w_wmask = r_hiMask;
      w_wdata = r_hiData;
    end
  end

  assign w_raddr = (r_state == IDLE) ? w_word : r_wordNext;

  // Write gated by reset so an aborted split store never lands its beat 2.
  always_ff @(posedge i_clk) begin
    if (w_we && i_reset) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wmask[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
    r_ramQ <= r_mem[w_raddr];
  end

  // Load formatting: on BEAT2 the low word is the held beat register and the
  // fresh RAM output supplies the high word.
  always_comb begin
    w_loadWide = (r_state == BEAT2) ? {r_ramQ, r_beat} : {{N{1'b0}}, r_ramQ};
    w_raw      = '0;
    for (int b = 0; b < NB; b++) begin
      w_raw[8*b +: 8] = w_loadWide[8*(b + int'(r_offset)) +: 8];
    end
    w_nbits = 8 << r_sz;
    case (r_sz)
      2'd0:    w_signBit = w_raw[7];
      2'd1:    w_signBit = w_raw[15];
      2'd2:    w_signBit = w_raw[31];
      default: w_signBit = w_raw[N-1];
    endcase
    w_signBit = w_signBit && !r_uns;
    w_loadResult = '0;
    for (int i = 0; i < N; i++) begin
      w_loadResult[i] = (i < w_nbits) ? w_raw[i] : w_signBit;
    end
    w_romExt = '0;
    w_romExt[M-1:0] = i_IM_readData;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_illegal)         w_nextState = RESP;
          else if (i_dataSelect) w_nextState = BEAT1;
          else if (i_req_write)  w_nextState = w_split ? BEAT2 : RESP;
          else                   w_nextState = BEAT1;
        end
      end
      BEAT1:   w_nextState = (!r_rom && r_split) ? BEAT2 : RESP;
      BEAT2:   w_nextState = RESP;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_err      <= 1'b0;
      r_readData <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE && w_accept) r_err <= w_illegal;
      if (r_state == BEAT1 && r_rom)                 r_readData <= w_romExt;
      else if (r_state == BEAT1 && !r_split)         r_readData <= w_loadResult;
      else if (r_state == BEAT2 && !r_write)         r_readData <= w_loadResult;
    end
  end

  // Request context; needs no reset because it is only read after an accept.
  always_ff @(posedge i_clk) begin
    if (r_state == IDLE && w_accept) begin
      r_write    <= i_req_write;
      r_rom      <= i_dataSelect;
      r_split    <= w_split;
      r_offset   <= w_offset;
      r_sz       <= w_sz;
      r_uns      <= i_memWidth[2];
      r_wordNext <= w_word + 1'b1;
      r_hiMask   <= w_maskWide[2*NB-1:NB];
      r_hiData   <= w_dataWide[2*N-1:N];
    end
    if (r_state == BEAT1 && r_split) r_beat <= r_ramQ;
  end

  assign o_req_ready  = (r_state == IDLE) && i_reset;
  assign o_resp_valid = (r_state == RESP);
  assign o_err        = r_err && o_resp_valid;
  assign o_readData   = r_readData;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: scoreboard bench for dmem_lsu. Requests push their expected
// response (err, readData, latency) into a queue; a monitor pops and
// compares whenever resp_valid is seen.
module tb_dmem_lsu;

  localparam int N = 64, M = 32, AW = 12, BW = 3;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          reqValid = 1'b0, reqWrite = 1'b0, dataSelect = 1'b0;
  logic [AW+BW-1:0] addr = '0;
  logic [2:0]    memWidth = '0;
  logic [N-1:0]  writeData = '0;
  logic [M-1:0]  imData = '0;
  logic          reqReady, respValid, err;
  logic [N-1:0]  readData;

  logic          v32 = 1'b0;
  logic [5:0]    a32 = '0;
  logic [2:0]    mw32 = 3'b011;
  logic [31:0]   wd32 = '0, im32 = '0, rd32;
  logic          rdy32, rv32, err32;

  always #5 clk = ~clk;

  dmem_lsu #(.N(N), .M(M), .AW(AW)) u_dut (
    .i_clk(clk), .i_reset(rstN), .i_req_valid(reqValid), .o_req_ready(reqReady),
    .i_req_write(reqWrite), .i_addr(addr), .i_memWidth(memWidth),
    .i_writeData(writeData), .i_dataSelect(dataSelect), .i_IM_readData(imData),
    .o_resp_valid(respValid), .o_readData(readData), .o_err(err));

  dmem_lsu #(.N(32), .M(32), .AW(4)) u_dut32 (
    .i_clk(clk), .i_reset(rstN), .i_req_valid(v32), .o_req_ready(rdy32),
    .i_req_write(1'b0), .i_addr(a32), .i_memWidth(mw32),
    .i_writeData(wd32), .i_dataSelect(1'b0), .i_IM_readData(im32),
    .o_resp_valid(rv32), .o_readData(rd32), .o_err(err32));

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          checkCount = 0;
  int          errorCount = 0;
  int          cyc = 0;
  logic [63:0] lastRead = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checkCount++;
    if (act !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%016h expected=0x%016h", name, act, expv);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstN && respValid) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected resp_valid", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput({e.name, " err"}, {63'd0, err}, {63'd0, e.err});
        checkOutput({e.name, " data"}, readData, e.data);
        checkOutput({e.name, " latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  task automatic waitReady(input string name, output logic ok);
    int n = 0;
    @(negedge clk);
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = reqReady;
    if (!ok) checkOutput({name, " ready timeout"}, 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input logic wr, input logic [2:0] mw, input logic [AW+BW-1:0] a,
                               input logic [63:0] wd, input logic ds, input logic expErr,
                               input logic [63:0] expData, input int lat, input string name);
    exp_t e;
    logic ok;
    waitReady(name, ok);
    if (!ok) return;
    reqWrite = wr; memWidth = mw; addr = a; writeData = wd; dataSelect = ds;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    e.err = expErr; e.data = expData; e.lat = lat; e.acc = cyc; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic storeReq(input logic [2:0] mw, input logic [AW+BW-1:0] a,
                          input logic [63:0] wd, input int lat, input string name);
    applyStimulus(1'b1, mw, a, wd, 1'b0, 1'b0, lastRead, lat, name);
  endtask

  task automatic loadReq(input logic [2:0] mw, input logic [AW+BW-1:0] a,
                         input logic [63:0] expv, input int lat, input string name);
    applyStimulus(1'b0, mw, a, 64'd0, 1'b0, 1'b0, expv, lat, name);
    lastRead = expv;
  endtask

  task automatic illegalReq(input logic wr, input logic [2:0] mw, input logic [AW+BW-1:0] a,
                            input logic [63:0] wd, input logic ds, input string name);
    applyStimulus(wr, mw, a, wd, ds, 1'b1, lastRead, 1, name);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    if (sbq.size() != 0) checkOutput("response timeout", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic ok;
    int   n;
    repeat (3) @(negedge clk);
    checkOutput("ready during reset", {63'd0, reqReady}, 64'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("reset ready", {63'd0, reqReady}, 64'd1);
    checkOutput("reset resp_valid", {63'd0, respValid}, 64'd0);
    checkOutput("reset readData", readData, 64'd0);

    // Aligned store then byte/half loads.
    storeReq(3'b011, 15'h10, 64'h1122334455667788, 1, "SD 0x10");
    loadReq(3'b000, 15'h10, 64'hFFFFFFFFFFFFFF88, 2, "LB 0x10");
    loadReq(3'b100, 15'h17, 64'h11, 2, "LBU 0x17");
    loadReq(3'b101, 15'h16, 64'h1122, 2, "LHU 0x16");
    loadReq(3'b010, 15'h14, 64'h11223344, 2, "LW 0x14");
    loadReq(3'b011, 15'h10, 64'h1122334455667788, 2, "LD 0x10");

    // Split load with ready held low for its duration.
    storeReq(3'b011, 15'h18, 64'hAABBCCDDEEFF0011, 1, "SD 0x18");
    loadReq(3'b010, 15'h16, 64'h0000000000111122, 3, "LW 0x16 split");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("split load ready low", {63'd0, reqReady}, 64'd0);
    end

    // Split store and neighbour bytes.
    storeReq(3'b001, 15'h1F, 64'hBEEF, 2, "SH 0x1F split");
    loadReq(3'b100, 15'h1F, 64'hEF, 2, "LBU 0x1F");
    loadReq(3'b100, 15'h20, 64'hBE, 2, "LBU 0x20");
    loadReq(3'b001, 15'h1E, 64'hFFFFFFFFFFFFEFBB, 2, "LH 0x1E");
    loadReq(3'b100, 15'h1D, 64'hCC, 2, "LBU 0x1D");
    loadReq(3'b001, 15'h1F, 64'hFFFFFFFFFFFFBEEF, 3, "LH 0x1F split");
    loadReq(3'b010, 15'h1C, 64'hFFFFFFFFEFBBCCDD, 2, "LW 0x1C");
    loadReq(3'b110, 15'h1C, 64'h00000000EFBBCCDD, 2, "LWU 0x1C");

    // Illegal requests leave RAM and readData alone.
    illegalReq(1'b0, 3'b111, 15'h10, 64'd0, 1'b0, "load width 111");
    illegalReq(1'b1, 3'b111, 15'h10, 64'd0, 1'b0, "store width 111");
    illegalReq(1'b1, 3'b100, 15'h10, 64'hFF, 1'b0, "store width 100");
    illegalReq(1'b1, 3'b011, 15'h10, 64'd0, 1'b1, "store dataSelect");
    loadReq(3'b011, 15'h10, 64'h1122334455667788, 2, "LD 0x10 after illegal");

    // ROM path: zero-extended, addr/width ignored, never split.
    imData = 32'h80000013;
    applyStimulus(1'b0, 3'b011, 15'h7FFF, 64'd0, 1'b1, 1'b0, 64'h0000000080000013, 2, "ROM read");
    lastRead = 64'h0000000080000013;

    // Wrap from last word to word 0.
    storeReq(3'b011, 15'h7FF8, 64'hFFFFFFFFFFFFFFFF, 1, "SD last");
    storeReq(3'b011, 15'h0000, 64'hFFFFFFFFFFFFFFFF, 1, "SD word0");
    storeReq(3'b011, 15'h7FFE, 64'h0102030405060708, 2, "SD wrap");
    loadReq(3'b011, 15'h7FF8, 64'h0708FFFFFFFFFFFF, 2, "LD last");
    loadReq(3'b011, 15'h0000, 64'hFFFF010203040506, 2, "LD word0");
    loadReq(3'b011, 15'h7FFE, 64'h0102030405060708, 3, "LD wrap split");
    drain();

    // Reset during beat 2 of a wrapping split store.
    waitReady("reset abort", ok);
    if (ok) begin
      reqWrite = 1'b1; memWidth = 3'b001; addr = 15'h7FFF; writeData = 64'h5A5A;
      dataSelect = 1'b0; reqValid = 1'b1;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      checkOutput("abort resp_valid", {63'd0, respValid}, 64'd0);
      checkOutput("abort readData", readData, 64'd0);
      checkOutput("abort ready in reset", {63'd0, reqReady}, 64'd0);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("abort ready after", {63'd0, reqReady}, 64'd1);
      checkOutput("abort resp_valid after", {63'd0, respValid}, 64'd0);
      lastRead = '0;
    end
    loadReq(3'b011, 15'h0000, 64'hFFFF010203040506, 2, "LD word0 after abort");
    drain();

    // N=32 build rejects a doubleword access.
    @(negedge clk);
    v32 = 1'b1;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rv32 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("N32 LD resp", {63'd0, rv32}, 64'd1);
    checkOutput("N32 LD err", {63'd0, err32}, 64'd1);
    checkOutput("N32 LD latency", 64'(n), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
